// File: rtl/split_arbiter_if.sv
// Bus-side signal bundle for split_arbiter: requests and slave selects in,
// grant and status out. The arbiter uses the slave modport.
interface split_arbiter_if #(
    parameter int NUM_MASTERS = 4,
    parameter int NUM_SLAVES  = 3,
    parameter int SLAVE_LEN   = 2
);
    localparam int MW = $clog2(NUM_MASTERS);

    logic [NUM_MASTERS-1:0]           req;
    logic [NUM_MASTERS*SLAVE_LEN-1:0] slave_sel;
    logic                             trans_done;
    logic [NUM_SLAVES-1:0]            split_en;
    logic [NUM_MASTERS-1:0]           grant;
    logic [MW-1:0]                    grant_id;
    logic [SLAVE_LEN-1:0]             sel_slave;
    logic                             bus_busy;
    logic                             arbiter_busy;
    logic [NUM_MASTERS-1:0]           split_pending;
    logic                             timeout;
    logic                             sel_err;

    modport master (
        output req, slave_sel, trans_done, split_en,
        input  grant, grant_id, sel_slave, bus_busy, arbiter_busy,
               split_pending, timeout, sel_err
    );

    modport slave (
        input  req, slave_sel, trans_done, split_en,
        output grant, grant_id, sel_slave, bus_busy, arbiter_busy,
               split_pending, timeout, sel_err
    );
endinterface

// File: rtl/split_arbiter.sv
// Split-transaction bus arbiter: IDLE/GRANT machine with parked-master resume
// priority, round-robin fallback, grant timeout and bad-slave-select flagging.
module split_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int NUM_SLAVES  = 3,
    parameter int SLAVE_LEN   = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic           clk,
    input  logic           reset,
    split_arbiter_if.slave bus
);
    localparam int MW = $clog2(NUM_MASTERS);
    localparam int TW = 16;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                 state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [MW-1:0]          grant_id_q, grant_id_d;
    logic [MW-1:0]          last_grant_q, last_grant_d;
    logic [SLAVE_LEN-1:0]   sel_slave_q, sel_slave_d;
    logic                   bus_busy_q, bus_busy_d;
    logic                   arbiter_busy_q, arbiter_busy_d;
    logic [NUM_MASTERS-1:0] split_pending_q, split_pending_d;
    logic [SLAVE_LEN-1:0]   park_slave_q [NUM_MASTERS];
    logic [SLAVE_LEN-1:0]   park_slave_d [NUM_MASTERS];
    logic                   timeout_q, timeout_d;
    logic                   sel_err_q, sel_err_d;
    logic [TW-1:0]          cnt_q, cnt_d;
    logic [NUM_MASTERS-1:0] req_prev_q, req_prev_d;

    logic [SLAVE_LEN-1:0]   sel [NUM_MASTERS];
    logic [NUM_MASTERS-1:0] sel_ok, eligible, resumed;
    logic [MW-1:0]          winner, rr_idx;
    logic [TW-1:0]          cnt_inc;
    logic                   cur_split, tmo_hit;

    function automatic logic slave_split(input logic [SLAVE_LEN-1:0] s,
                                         input logic [NUM_SLAVES-1:0] en);
        logic hit;
        hit = 1'b0;
        for (int j = 0; j < NUM_SLAVES; j++)
            if (s == SLAVE_LEN'(j)) hit = en[j];
        return hit;
    endfunction

    // A parked master may only come back once the slave it was parked on lets go.
    always_comb begin
        for (int i = 0; i < NUM_MASTERS; i++) begin
            sel[i]      = bus.slave_sel[i*SLAVE_LEN +: SLAVE_LEN];
            sel_ok[i]   = int'(sel[i]) < NUM_SLAVES;
            eligible[i] = bus.req[i] && sel_ok[i] && !slave_split(sel[i], bus.split_en) &&
                          (!split_pending_q[i] || !slave_split(park_slave_q[i], bus.split_en));
            resumed[i]  = eligible[i] && split_pending_q[i];
        end
    end

    // Descending scans so the final assignment is the highest-priority candidate.
    always_comb begin
        winner = '0;
        rr_idx = '0;
        if (|resumed) begin
            for (int i = NUM_MASTERS - 1; i >= 0; i--)
                if (resumed[i]) winner = MW'(i);
        end else begin
            for (int k = NUM_MASTERS; k >= 1; k--) begin
                rr_idx = MW'((int'(last_grant_q) + k) % NUM_MASTERS);
                if (eligible[rr_idx]) winner = rr_idx;
            end
        end
    end

    assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    assign tmo_hit   = cnt_inc >= TW'(TIMEOUT);
    assign cur_split = slave_split(sel_slave_q, bus.split_en);

    always_comb begin
        // NOTE: every _d gets a default before the case so no latch is inferred.
        state_d         = state_q;
        grant_d         = grant_q;
        grant_id_d      = grant_id_q;
        sel_slave_d     = sel_slave_q;
        bus_busy_d      = bus_busy_q;
        last_grant_d    = last_grant_q;
        cnt_d           = cnt_q;
        timeout_d       = 1'b0;
        split_pending_d = split_pending_q & bus.req;
        park_slave_d    = park_slave_q;
        req_prev_d      = bus.req;
        sel_err_d       = |(bus.req & ~req_prev_q & ~sel_ok);

        case (state_q)
            IDLE: begin
                if (|eligible) begin
                    state_d                 = GRANT;
                    grant_d                 = NUM_MASTERS'(1) << winner;
                    grant_id_d              = winner;
                    sel_slave_d             = sel[winner];
                    bus_busy_d              = 1'b1;
                    cnt_d                   = '0;
                    split_pending_d[winner] = 1'b0;
                end
            end
            GRANT: begin
                cnt_d = cnt_inc;
                if (bus.trans_done || !bus.req[grant_id_q] || cur_split || tmo_hit) begin
                    state_d      = IDLE;
                    grant_d      = '0;
                    bus_busy_d   = 1'b0;
                    last_grant_d = grant_id_q;
                    // Completion wins over split; only an unfinished transfer parks or times out.
                    if (!bus.trans_done && bus.req[grant_id_q]) begin
                        if (cur_split) begin
                            split_pending_d[grant_id_q] = 1'b1;
                            park_slave_d[grant_id_q]    = sel_slave_q;
                        end else begin
                            timeout_d = 1'b1;
                        end
                    end
                end
            end
        endcase

        arbiter_busy_d = bus_busy_d | (|split_pending_d);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            grant_q         <= '0;
            grant_id_q      <= '0;
            last_grant_q    <= MW'(NUM_MASTERS - 1);
            sel_slave_q     <= '0;
            bus_busy_q      <= 1'b0;
            arbiter_busy_q  <= 1'b0;
            split_pending_q <= '0;
            timeout_q       <= 1'b0;
            sel_err_q       <= 1'b0;
            cnt_q           <= '0;
            req_prev_q      <= '0;
            // NOTE: the park slots are a handful of flops, so they are reset like any other state.
            for (int i = 0; i < NUM_MASTERS; i++) park_slave_q[i] <= '0;
        end else begin
            state_q         <= state_d;
            grant_q         <= grant_d;
            grant_id_q      <= grant_id_d;
            last_grant_q    <= last_grant_d;
            sel_slave_q     <= sel_slave_d;
            bus_busy_q      <= bus_busy_d;
            arbiter_busy_q  <= arbiter_busy_d;
            split_pending_q <= split_pending_d;
            timeout_q       <= timeout_d;
            sel_err_q       <= sel_err_d;
            cnt_q           <= cnt_d;
            req_prev_q      <= req_prev_d;
            for (int i = 0; i < NUM_MASTERS; i++) park_slave_q[i] <= park_slave_d[i];
        end
    end

    assign bus.grant         = grant_q;
    assign bus.grant_id      = grant_id_q;
    assign bus.sel_slave     = sel_slave_q;
    assign bus.bus_busy      = bus_busy_q;
    assign bus.arbiter_busy  = arbiter_busy_q;
    assign bus.split_pending = split_pending_q;
    assign bus.timeout       = timeout_q;
    assign bus.sel_err       = sel_err_q;
endmodule

// File: tb/tb_split_arbiter.sv
// Bench for split_arbiter: directed scenarios plus random traffic, scored against
// a transaction-level model through event queues drained by a negedge monitor.
module tb_split_arbiter;
    localparam int NM = 4;
    localparam int NS = 3;
    localparam int SL = 2;
    localparam int TO = 20;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    split_arbiter_if #(.NUM_MASTERS(NM), .NUM_SLAVES(NS), .SLAVE_LEN(SL)) ifc ();

    split_arbiter #(.NUM_MASTERS(NM), .NUM_SLAVES(NS), .SLAVE_LEN(SL), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {int cyc; int id; int slv;} ev_t;
    ev_t gq[$];
    ev_t tq[$];
    ev_t sq[$];

    int cyc = 0;
    int m_owner, m_slave, m_held, m_last;
    bit m_parked [NM];
    int m_pslave [NM];
    bit m_prev   [NM];

    function automatic int sel_of(int i);
        return int'(ifc.slave_sel[i*SL +: SL]);
    endfunction

    function automatic bit split_on(int s);
        return (s < NS) ? ifc.split_en[s] : 1'b0;
    endfunction

    function automatic bit elig(int i);
        int s;
        s = sel_of(i);
        return ifc.req[i] && s < NS && !split_on(s) && (!m_parked[i] || !split_on(m_pslave[i]));
    endfunction

    function automatic logic [NM-1:0] exp_pending();
        logic [NM-1:0] v;
        for (int i = 0; i < NM; i++) v[i] = m_parked[i];
        return v;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_slave = 0; m_held = 0; m_last = NM - 1;
        for (int i = 0; i < NM; i++) begin
            m_parked[i] = 1'b0; m_pslave[i] = 0; m_prev[i] = 1'b0;
        end
        gq.delete(); tq.delete(); sq.delete();
    endtask

    task automatic model_step();
        bit serr, leave;
        int best, best_key, key;
        cyc++;
        serr = 1'b0;
        for (int i = 0; i < NM; i++) begin
            if (ifc.req[i] && !m_prev[i] && sel_of(i) >= NS) serr = 1'b1;
        end
        if (serr) sq.push_back('{cyc, 0, 0});
        if (m_owner < 0) begin
            // Resumed parked masters rank by index ahead of every round-robin distance.
            best = -1; best_key = 1000;
            for (int i = 0; i < NM; i++) begin
                if (elig(i)) begin
                    key = m_parked[i] ? i : NM + (i - m_last - 1 + NM) % NM;
                    if (key < best_key) begin best_key = key; best = i; end
                end
            end
            if (best >= 0) begin
                m_owner = best; m_slave = sel_of(best); m_held = 0; m_parked[best] = 1'b0;
                gq.push_back('{cyc, best, m_slave});
            end
        end else begin
            m_held++;
            leave = 1'b1;
            if (ifc.trans_done) begin
            end else if (!ifc.req[m_owner]) begin
            end else if (split_on(m_slave)) begin
                m_parked[m_owner] = 1'b1; m_pslave[m_owner] = m_slave;
            end else if (m_held >= TO) begin
                tq.push_back('{cyc, m_owner, 0});
            end else begin
                leave = 1'b0;
            end
            if (leave) begin m_last = m_owner; m_owner = -1; end
        end
        for (int i = 0; i < NM; i++) begin
            if (!ifc.req[i]) m_parked[i] = 1'b0;
            m_prev[i] = ifc.req[i];
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) model_reset();
            else model_step();
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [NM-1:0] prev_g;
        ev_t e;
        prev_g = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_g = '0;
            end else begin
                check("mon_grant", ifc.grant, (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
                check("mon_bus_busy", ifc.bus_busy, m_owner >= 0);
                check("mon_split_pending", ifc.split_pending, exp_pending());
                check("mon_arbiter_busy", ifc.arbiter_busy, (m_owner >= 0) || (exp_pending() != 0));

                while (gq.size() != 0 && gq[0].cyc < cyc) begin
                    e = gq.pop_front(); check("grant_missed_cycle", cyc, e.cyc);
                end
                if (ifc.grant != 0 && prev_g == 0) begin
                    check("grant_expected", gq.size() != 0, 1);
                    if (gq.size() != 0) begin
                        e = gq.pop_front();
                        check("grant_cycle", cyc, e.cyc);
                        check("grant_id", ifc.grant_id, e.id);
                        check("grant_sel_slave", ifc.sel_slave, e.slv);
                    end
                end
                prev_g = ifc.grant;

                while (tq.size() != 0 && tq[0].cyc < cyc) begin
                    e = tq.pop_front(); check("timeout_missed_cycle", cyc, e.cyc);
                end
                if (ifc.timeout) begin
                    check("timeout_expected", tq.size() != 0, 1);
                    if (tq.size() != 0) begin e = tq.pop_front(); check("timeout_cycle", cyc, e.cyc); end
                end

                while (sq.size() != 0 && sq[0].cyc < cyc) begin
                    e = sq.pop_front(); check("sel_err_missed_cycle", cyc, e.cyc);
                end
                if (ifc.sel_err) begin
                    check("sel_err_expected", sq.size() != 0, 1);
                    if (sq.size() != 0) begin e = sq.pop_front(); check("sel_err_cycle", cyc, e.cyc); end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        ifc.req = '0; ifc.slave_sel = '0; ifc.trans_done = 1'b0; ifc.split_en = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 reset = 1'b0;
        drive_idle();
        #1;
        check("rst_grant", ifc.grant, 0);
        check("rst_grant_id", ifc.grant_id, 0);
        check("rst_sel_slave", ifc.sel_slave, 0);
        check("rst_bus_busy", ifc.bus_busy, 0);
        check("rst_arbiter_busy", ifc.arbiter_busy, 0);
        check("rst_split_pending", ifc.split_pending, 0);
        check("rst_timeout", ifc.timeout, 0);
        check("rst_sel_err", ifc.sel_err, 0);
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic wait_grant(output int id, output int gap);
        id = -1; gap = 0;
        for (int t = 0; t < 64; t++) begin
            if (ifc.grant != 0) begin
                id = int'(ifc.grant_id);
                break;
            end
            gap++;
            tick();
        end
        check("grant_within_bound", id >= 0, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: actual=still running required=finished");
        n_fail++;
        $fatal(1, "watchdog expired");
    end

    // ---------------- test sequence ----------------
    initial begin
        int id, gap, cnt, ne, ng;
        int exp_order [5];
        exp_order = '{0, 1, 2, 3, 0};
        drive_idle();

        // Round-robin order with one idle cycle between grants.
        do_reset();
        ifc.req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            wait_grant(id, gap);
            check($sformatf("rr_order_%0d", n), id, exp_order[n]);
            if (n > 0) check($sformatf("rr_gap_%0d", n), gap, 1);
            tick(); tick();
            ifc.trans_done = 1'b1;
            tick();
            ifc.trans_done = 1'b0;
        end
        ifc.req = '0;
        tick();

        // Split parks m1, m2 runs, then m1 resumes ahead of m3.
        do_reset();
        ifc.slave_sel = {2'd1, 2'd0, 2'd2, 2'd0};
        ifc.req = 4'b0010;
        wait_grant(id, gap);
        check("split_first_id", id, 1);
        check("split_first_slave", ifc.sel_slave, 2);
        ifc.req = 4'b1110;
        ifc.split_en = 3'b100;
        tick();
        check("split_grant_dropped", ifc.grant, 0);
        check("split_pending_m1", ifc.split_pending, 4'b0010);
        tick();
        check("split_m2_granted", ifc.grant, 4'b0100);
        ifc.trans_done = 1'b1;
        ifc.split_en = 3'b000;
        tick();
        ifc.trans_done = 1'b0;
        tick();
        check("split_m1_resumed", ifc.grant, 4'b0010);
        check("split_pending_cleared", ifc.split_pending, 0);
        ifc.trans_done = 1'b1;
        tick();
        ifc.trans_done = 1'b0;
        ifc.req = '0;
        tick();

        // Timeout after TO grant cycles.
        do_reset();
        ifc.req = 4'b0001;
        wait_grant(id, gap);
        cnt = 0;
        while (ifc.grant != 0 && cnt < 100) begin cnt++; tick(); end
        check("tmo_grant_cycles", cnt, TO);
        check("tmo_pulse", ifc.timeout, 1);
        check("tmo_grant_zero", ifc.grant, 0);
        ifc.req = '0;
        tick();
        check("tmo_pulse_one_cycle", ifc.timeout, 0);

        // Out-of-range slave select: one sel_err pulse, never granted.
        do_reset();
        ifc.slave_sel = {2'd3, 2'd0, 2'd0, 2'd0};
        ifc.req = 4'b1000;
        ne = 0; ng = 0;
        repeat (12) begin
            tick();
            if (ifc.sel_err) ne++;
            if (ifc.grant != 0) ng++;
        end
        check("bad_sel_err_pulses", ne, 1);
        check("bad_sel_grants", ng, 0);
        ifc.req = '0;
        tick();

        // Completion and split in the same cycle releases without parking.
        do_reset();
        ifc.slave_sel = {2'd0, 2'd0, 2'd0, 2'd1};
        ifc.req = 4'b0001;
        wait_grant(id, gap);
        ifc.trans_done = 1'b1;
        ifc.split_en = 3'b010;
        tick();
        check("done_split_grant", ifc.grant, 0);
        check("done_split_pending", ifc.split_pending, 0);
        check("done_split_busy", ifc.arbiter_busy, 0);
        drive_idle();
        tick();

        // Reset in the middle of a grant, then a fresh request.
        do_reset();
        ifc.req = 4'b0001;
        wait_grant(id, gap);
        tick();
        check("mid_reset_busy_before", ifc.bus_busy, 1);
        do_reset();
        ifc.req = 4'b0100;
        tick();
        check("post_reset_grant", ifc.grant, 4'b0100);
        ifc.trans_done = 1'b1;
        tick();
        drive_idle();
        tick();

        // Random traffic scored by the model.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            bit slow;
            slow = ((c / 200) % 2) == 1;
            for (int i = 0; i < NM; i++) begin
                if ($urandom_range(0, slow ? 40 : 7) == 0) ifc.req[i] = ~ifc.req[i];
                if ($urandom_range(0, 15) == 0)
                    ifc.slave_sel[i*SL +: SL] = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            end
            for (int j = 0; j < NS; j++)
                if ($urandom_range(0, 11) == 0) ifc.split_en[j] = ~ifc.split_en[j];
            ifc.trans_done = ($urandom_range(0, slow ? 60 : 5) == 0);
            tick();
        end
        drive_idle();
        repeat (5) tick();
        check("grant_events_left", gq.size(), 0);
        check("timeout_events_left", tq.size(), 0);
        check("sel_err_events_left", sq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/split_arbiter.md
SPLIT_ARBITER -- requirements
Module: split_arbiter

Interface
REQ-001 Parameters; each SHALL be used as given:
- NUM_MASTERS, default 4: number of masters, legal 2..8.
- NUM_SLAVES, default 3: number of slaves, legal 1..(2**SLAVE_LEN).
- SLAVE_LEN, default 2: width of the slave-select field.
- TIMEOUT, default 255: maximum number of cycles in one grant, legal 1..65535.
- MW = $clog2(NUM_MASTERS); TW = 16.

REQ-002 Ports (name  direction  width  meaning):
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  NUM_MASTERS  per-master bus request.
- slave_sel  in  NUM_MASTERS*SLAVE_LEN  per-master target slave; master i occupies bits [i*SLAVE_LEN +: SLAVE_LEN].
- trans_done  in  1  granted transaction complete.
- split_en  in  NUM_SLAVES  per-slave split request.
- grant  out  NUM_MASTERS  one-hot or zero grant.
- grant_id  out  MW  index of the granted master.
- sel_slave  out  SLAVE_LEN  slave latched at grant.
- bus_busy  out  1  a grant is active.
- arbiter_busy  out  1  bus_busy OR any split pending.
- split_pending  out  NUM_MASTERS  per-master parked flag.
- timeout  out  1  one-cycle pulse when a grant is revoked by timeout.
- sel_err  out  1  one-cycle pulse when an out-of-range slave is requested.

Function
REQ-003 The block SHALL have two states, IDLE and GRANT; all outputs SHALL be registered.

REQ-004 Eligibility: master i SHALL be eligible when all of the following hold:
- req[i] = 1;
- its slave_sel < NUM_SLAVES;
- split_en of its target slave = 0;
- it is not parked, OR it is parked and its recorded slave has deasserted split_en.

REQ-005 Arbitration in IDLE: when any master is eligible, the block SHALL move to GRANT with grant, grant_id and sel_slave valid on the next edge.
- Request-to-grant latency is 1 cycle.

REQ-006 Priority: resumed parked masters SHALL win first, lowest index among them; otherwise the winner SHALL be chosen round-robin, searching upward from (last_grant+1) mod NUM_MASTERS.
- After reset, last_grant = NUM_MASTERS-1, so master 0 has first priority.

REQ-007 When a master is granted, its split_pending bit SHALL clear in the same edge.

REQ-008 A master whose slave_sel >= NUM_SLAVES SHALL never be granted; sel_err SHALL pulse once per rising edge of that master's req.

REQ-009 GRANT exits, evaluated in this priority order, each returning to IDLE with grant = 0 on the next edge:
- (a) trans_done = 1: release.
- (b) req[grant_id] = 0: release.
- (c) split_en[sel_slave] = 1: park; split_pending[grant_id] is set, sel_slave is recorded per master, and no transaction-done is implied.
- (d) the grant cycle counter reaches TIMEOUT: revoke, with timeout pulsing for 1 cycle.

REQ-010 Events (a) and (c) in the same cycle SHALL release without parking.

REQ-011 On every exit from GRANT, last_grant SHALL be updated to grant_id.

REQ-012 In IDLE there SHALL be at least one cycle with grant = 0 between consecutive grants; back-to-back grants are forbidden.

REQ-013 The grant cycle counter SHALL clear on entry to GRANT and count each cycle in GRANT.
- It SHALL saturate at 16 bits and never wrap.

REQ-014 A parked master that deasserts req SHALL have its split_pending bit cleared on the next edge.

REQ-015 grant SHALL be zero whenever bus_busy = 0.

REQ-016 split_en on a slave not targeted by the current grant SHALL NOT affect the current grant.

Reset
REQ-017 While reset = 0, the following SHALL hold asynchronously:
- state = IDLE;
- grant = 0, grant_id = 0, sel_slave = 0;
- bus_busy = 0, arbiter_busy = 0;
- split_pending = 0;
- timeout = 0, sel_err = 0;
- counter = 0;
- last_grant = NUM_MASTERS-1.

REQ-018 Reset asserted during GRANT SHALL drop the grant immediately, with no timeout pulse.
- After release, arbitration SHALL resume on the first edge with an eligible request.

Verification
REQ-019 The bench SHALL cover these scenarios (NUM_MASTERS=4, NUM_SLAVES=3, TIMEOUT=20):
- req=4'b1111 held, trans_done pulsed 3 cycles after each grant -> grants in order 0,1,2,3,0, with 1 idle cycle between grants.
- m1 granted to slave 2, then split_en[2]=1 -> grant cleared next edge, split_pending=4'b0010, and m2 is granted. After m2's trans_done and split_en[2]=0, m1 is granted before m3, even though m3 is next in round-robin.
- m0 granted with no trans_done -> timeout pulses on the cycle after the 20th GRANT cycle, and grant=0 on the same edge.
- m3 with slave_sel=3 -> never granted, and sel_err pulses exactly once.
- trans_done and split_en[sel_slave] asserted in the same cycle -> released, split_pending stays 0.
- reset=0 during GRANT -> all outputs at reset values in the same cycle; after release, req=4'b0100 -> grant=4'b0100 one cycle later.
